// File: rtl/prga_fifo_pkg.sv
// Shared helpers and types for the PRGA occupancy FIFO.
// Covers sizing functions, read-mode encodings and packed status/error bundles.
package prga_fifo_pkg;

    localparam int unsigned NON_LOOKAHEAD = 0;
    localparam int unsigned LOOKAHEAD     = 1;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    localparam fifo_status_t STATUS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0
    };

    function automatic int unsigned fifo_depth(input int unsigned depth_log2);
        return 32'd1 << depth_log2;
    endfunction

    // One extra bit so that wr_ptr - rd_ptr distinguishes full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth_log2);
        return depth_log2 + 32'd1;
    endfunction

    function automatic fifo_status_t status_of(input int unsigned cnt,
                                               input int unsigned depth,
                                               input int unsigned af_thresh,
                                               input int unsigned ae_thresh);
        fifo_status_t s;
        s.empty        = (cnt == 32'd0);
        s.full         = (cnt == depth);
        s.almost_empty = (cnt <= ae_thresh);
        s.almost_full  = (cnt >= af_thresh);
        return s;
    endfunction

endpackage

// File: rtl/prga_fifo_storage.sv
// Flop-based FIFO storage array.
// Provides one synchronous write port and one asynchronous read port.
module prga_fifo_storage #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prga_fifo_occ.sv
// Parametrised PRGA FIFO with occupancy count, almost-full/empty thresholds
// and sticky overflow/underflow flags; dout is registered or fall-through.
module prga_fifo_occ
    import prga_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned LOOKAHEAD  = 0,
    parameter int unsigned AF_THRESH  = (32'd1 << DEPTH_LOG2) - 32'd2,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = fifo_depth(DEPTH_LOG2);
    localparam int unsigned PW    = ptr_width(DEPTH_LOG2);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;

    fifo_status_t status_q, status_d;
    fifo_err_t    err_q, err_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        wr_acc   = wr && !status_q.full;
        rd_acc   = rd && !status_q.empty;
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, rd_acc};
        // Modulo-2*DEPTH difference is exactly the occupancy.
        count_d  = wr_ptr_d - rd_ptr_d;
        status_d = status_of(32'(count_d), DEPTH, AF_THRESH, AE_THRESH);

        // A new error in the same cycle as clr_err keeps the flag set.
        err_d.overflow  = (wr && status_q.full)  || (err_q.overflow  && !clr_err);
        err_d.underflow = (rd && status_q.empty) || (err_q.underflow && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= STATUS_RESET;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    prga_fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_storage (
        .clk   (clk),
        .we    (wr_acc && rst_n),
        .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata (din),
        .raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata (rd_data)
    );

    if (LOOKAHEAD == prga_fifo_pkg::NON_LOOKAHEAD) begin : g_reg_dout
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign dout = dout_q;
    end else begin : g_fwft
        assign dout = rd_data;
    end

    assign count        = count_q;
    assign empty        = status_q.empty;
    assign full         = status_q.full;
    assign almost_empty = status_q.almost_empty;
    assign almost_full  = status_q.almost_full;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_prga_fifo_occ.sv
// Scoreboard bench: a queue model predicts per-cycle state for a registered
// and a fall-through instance driven by identical stimulus.
module tb_prga_fifo_occ;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] din = 8'h00;

    logic       full0, af0, empty0, ae0, ov0, un0;
    logic       full1, af1, empty1, ae1, ov1, un1;
    logic [7:0] dout0, dout1;
    logic [2:0] count0, count1;

    always #5 clk = ~clk;

    prga_fifo_occ #(
        .DATA_WIDTH (8),
        .DEPTH_LOG2 (2),
        .LOOKAHEAD  (0),
        .AF_THRESH  (3),
        .AE_THRESH  (1)
    ) u_dut_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr),
        .din          (din),
        .full         (full0),
        .almost_full  (af0),
        .rd           (rd),
        .dout         (dout0),
        .empty        (empty0),
        .almost_empty (ae0),
        .count        (count0),
        .clr_err      (clr_err),
        .overflow     (ov0),
        .underflow    (un0)
    );

    prga_fifo_occ #(
        .DATA_WIDTH (8),
        .DEPTH_LOG2 (2),
        .LOOKAHEAD  (1),
        .AF_THRESH  (3),
        .AE_THRESH  (1)
    ) u_dut_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr),
        .din          (din),
        .full         (full1),
        .almost_full  (af1),
        .rd           (rd),
        .dout         (dout1),
        .empty        (empty1),
        .almost_empty (ae1),
        .count        (count1),
        .clr_err      (clr_err),
        .overflow     (ov1),
        .underflow    (un1)
    );

    typedef struct {
        int  cnt;
        bit  emp;
        bit  ful;
        bit  ae;
        bit  af;
        bit  ov;
        bit  un;
        int  d0;
        bit  d1_valid;
        int  d1;
    } exp_t;

    exp_t exp_q[$];

    byte unsigned mq[$];
    bit           m_ov = 1'b0;
    bit           m_un = 1'b0;
    byte unsigned m_last = 8'h00;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the model's prediction for after the edge.
    task automatic step(input bit r, input bit w, input byte unsigned d, input bit p,
                        input bit c);
        exp_t e;
        int   sz;
        @(negedge clk);
        rst_n   = r;
        wr      = w;
        din     = d;
        rd      = p;
        clr_err = c;
        sz = mq.size();
        if (!r) begin
            mq.delete();
            m_ov   = 1'b0;
            m_un   = 1'b0;
            m_last = 8'h00;
        end else begin
            m_ov = (w && sz == DEPTH) || (m_ov && !c);
            m_un = (p && sz == 0) || (m_un && !c);
            if (p && sz > 0) m_last = mq.pop_front();
            if (w && sz < DEPTH) mq.push_back(d);
        end
        e.cnt      = mq.size();
        e.emp      = (mq.size() == 0);
        e.ful      = (mq.size() == DEPTH);
        e.ae       = (mq.size() <= 1);
        e.af       = (mq.size() >= 3);
        e.ov       = m_ov;
        e.un       = m_un;
        e.d0       = int'(m_last);
        e.d1_valid = (mq.size() > 0);
        e.d1       = e.d1_valid ? int'(mq[0]) : 0;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one prediction per clock and compares both instances.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count_reg",  int'(count0), e.cnt);
                check("count_fwft", int'(count1), e.cnt);
                check("empty",      int'(empty0), int'(e.emp));
                check("full",       int'(full0),  int'(e.ful));
                check("almost_empty", int'(ae0),  int'(e.ae));
                check("almost_full",  int'(af0),  int'(e.af));
                check("overflow",   int'(ov0),    int'(e.ov));
                check("underflow",  int'(un0),    int'(e.un));
                check("flags_fwft", int'({empty1, full1, ae1, af1, ov1, un1}),
                      int'({e.emp, e.ful, e.ae, e.af, e.ov, e.un}));
                check("dout_reg",   int'(dout0),  e.d0);
                if (e.d1_valid) check("dout_fwft", int'(dout1), e.d1);
            end
        end
    end

    initial begin
        int wp;
        // Reset held with wr asserted.
        step(0, 1, 8'hAA, 0, 0);
        step(0, 1, 8'hAA, 0, 0);
        // Fill, then one dropped write.
        step(1, 1, 8'h11, 0, 0);
        step(1, 1, 8'h22, 0, 0);
        step(1, 1, 8'h33, 0, 0);
        step(1, 1, 8'h44, 0, 0);
        step(1, 1, 8'h55, 0, 0);
        // Drain with one read past empty.
        for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 1, 0);
        // Fall-through visibility of a single word.
        step(1, 1, 8'hA5, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 1);
        // Simultaneous read/write at count 2 across pointer wrap.
        step(1, 1, 8'h01, 0, 0);
        step(1, 1, 8'h02, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 8'(i + 3), 1, 0);
        // Overflow, clear, then reset mid-operation.
        for (int i = 0; i < 3; i++) step(1, 1, 8'(8'hC0 + i), 0, 0);
        step(1, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 1, 0);
        step(0, 1, 8'hEE, 1, 0);
        step(1, 1, 8'h7E, 0, 0);
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 0, 0);
        // Randomised traffic with fill/drain bias phases.
        for (int i = 0; i < 600; i++) begin
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 99) < wp,
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 15) == 0);
        end
        step(1, 0, 8'h00, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
